// File: rtl/seq_packet_bus_sink_if.sv
// Sequence-packet bus between the last bus node / downstream encoder and the sink.
// master = upstream packet source plus downstream consumer; slave = the sink itself.
interface seq_packet_bus_sink_if #(
    parameter int unsigned PACKET_SIZE = 4,
    parameter int unsigned LL_BITS     = 8,
    parameter int unsigned ML_BITS     = 8,
    parameter int unsigned OFF_BITS    = 16
);
    logic                            i_valid;
    logic [PACKET_SIZE-1:0]          i_strb;
    logic [LL_BITS*PACKET_SIZE-1:0]  i_ll;
    logic [ML_BITS*PACKET_SIZE-1:0]  i_ml;
    logic [OFF_BITS*PACKET_SIZE-1:0] i_offset;
    logic [ML_BITS*PACKET_SIZE-1:0]  i_overlap;
    logic [PACKET_SIZE-1:0]          i_eoj;
    logic [PACKET_SIZE-1:0]          i_delim;
    logic                            i_ready;

    logic                            o_seq_valid;
    logic [LL_BITS-1:0]              o_seq_ll;
    logic [ML_BITS-1:0]              o_seq_ml;
    logic [OFF_BITS-1:0]             o_seq_offset;
    logic [ML_BITS-1:0]              o_seq_overlap;
    logic                            o_seq_eoj;
    logic                            o_seq_delim;
    logic                            o_seq_last;
    logic                            o_seq_ready;

    modport master (
        output i_valid, i_strb, i_ll, i_ml, i_offset, i_overlap, i_eoj, i_delim,
        input  i_ready,
        input  o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_overlap,
               o_seq_eoj, o_seq_delim, o_seq_last,
        output o_seq_ready
    );

    modport slave (
        input  i_valid, i_strb, i_ll, i_ml, i_offset, i_overlap, i_eoj, i_delim,
        output i_ready,
        output o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_overlap,
               o_seq_eoj, o_seq_delim, o_seq_last,
        input  o_seq_ready
    );
endinterface

// File: rtl/seq_packet_bus_sink.sv
// Tail of the sequence-packet bus: buffers one packet and emits its strobed lanes
// in ascending order, one per cycle, while counting jobs and flagging malformed packets.
module seq_packet_bus_sink #(
    parameter int unsigned PACKET_SIZE  = 4,
    parameter int unsigned LL_BITS      = 8,
    parameter int unsigned ML_BITS      = 8,
    parameter int unsigned OFF_BITS     = 16,
    parameter int unsigned JOB_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_packet_bus_sink_if.slave    bus,
    output logic [JOB_CNT_BITS-1:0] o_job_count,
    output logic                    o_err
);
    logic [PACKET_SIZE-1:0]          rem_q, rem_d;
    logic [LL_BITS*PACKET_SIZE-1:0]  ll_q, ll_d;
    logic [ML_BITS*PACKET_SIZE-1:0]  ml_q, ml_d;
    logic [OFF_BITS*PACKET_SIZE-1:0] off_q, off_d;
    logic [ML_BITS*PACKET_SIZE-1:0]  ovl_q, ovl_d;
    logic [PACKET_SIZE-1:0]          eoj_q, eoj_d;
    logic [PACKET_SIZE-1:0]          delim_q, delim_d;
    logic [JOB_CNT_BITS-1:0]         job_q, job_d;
    logic                            err_q, err_d;

    logic [PACKET_SIZE-1:0] sel_oh;
    logic [PACKET_SIZE-1:0] hi_strb_oh;
    logic                   seq_valid, seq_last, seq_eoj, fire, accept, bad_pkt;

    always_comb begin
        // Lowest remaining lane as a one-hot; zero when the buffer is empty so all data outputs read 0.
        sel_oh    = rem_q & (~rem_q + PACKET_SIZE'(1));
        seq_valid = |rem_q;
        seq_last  = seq_valid && ((rem_q & ~sel_oh) == '0);

        bus.o_seq_ll      = '0;
        bus.o_seq_ml      = '0;
        bus.o_seq_offset  = '0;
        bus.o_seq_overlap = '0;
        seq_eoj           = 1'b0;
        bus.o_seq_delim   = 1'b0;
        for (int unsigned k = 0; k < PACKET_SIZE; k++) begin
            if (sel_oh[k]) begin
                bus.o_seq_ll      = bus.o_seq_ll      | ll_q[k*LL_BITS +: LL_BITS];
                bus.o_seq_ml      = bus.o_seq_ml      | ml_q[k*ML_BITS +: ML_BITS];
                bus.o_seq_offset  = bus.o_seq_offset  | off_q[k*OFF_BITS +: OFF_BITS];
                bus.o_seq_overlap = bus.o_seq_overlap | ovl_q[k*ML_BITS +: ML_BITS];
                seq_eoj           = seq_eoj | eoj_q[k];
                bus.o_seq_delim   = bus.o_seq_delim | delim_q[k];
            end
        end
        bus.o_seq_valid = seq_valid;
        bus.o_seq_last  = seq_last;
        bus.o_seq_eoj   = seq_eoj;

        fire        = seq_valid && bus.o_seq_ready;
        bus.i_ready = (rem_q == '0) || (fire && seq_last);
        accept      = bus.i_valid && bus.i_ready;

        hi_strb_oh = '0;
        for (int unsigned k = 0; k < PACKET_SIZE; k++) begin
            if (bus.i_strb[k]) begin
                hi_strb_oh    = '0;
                hi_strb_oh[k] = 1'b1;
            end
        end
        // eoj may only sit on the highest strobed lane; an empty packet with any eoj is also bad.
        bad_pkt = |(bus.i_eoj & ~bus.i_strb) || |(bus.i_eoj & bus.i_strb & ~hi_strb_oh);

        rem_d   = fire ? (rem_q & ~sel_oh) : rem_q;
        ll_d    = ll_q;
        ml_d    = ml_q;
        off_d   = off_q;
        ovl_d   = ovl_q;
        eoj_d   = eoj_q;
        delim_d = delim_q;
        if (accept) begin
            rem_d   = bus.i_strb;
            ll_d    = bus.i_ll;
            ml_d    = bus.i_ml;
            off_d   = bus.i_offset;
            ovl_d   = bus.i_overlap;
            eoj_d   = bus.i_eoj;
            delim_d = bus.i_delim;
        end

        job_d = (fire && seq_eoj) ? job_q + JOB_CNT_BITS'(1) : job_q;
        err_d = err_q | (accept && bad_pkt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            ll_q    <= '0;
            ml_q    <= '0;
            off_q   <= '0;
            ovl_q   <= '0;
            eoj_q   <= '0;
            delim_q <= '0;
            job_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            ll_q    <= ll_d;
            ml_q    <= ml_d;
            off_q   <= off_d;
            ovl_q   <= ovl_d;
            eoj_q   <= eoj_d;
            delim_q <= delim_d;
            job_q   <= job_d;
            err_q   <= err_d;
        end
    end

    assign o_job_count = job_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_seq_packet_bus_sink.sv
// Scoreboard bench for seq_packet_bus_sink: expected lanes queued on accept, compared on emit.
module tb_seq_packet_bus_sink;
    localparam int unsigned PS  = 4;
    localparam int unsigned LLB = 8;
    localparam int unsigned MLB = 8;
    localparam int unsigned OFB = 16;
    localparam int unsigned JCB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_packet_bus_sink_if #(.PACKET_SIZE(PS), .LL_BITS(LLB), .ML_BITS(MLB), .OFF_BITS(OFB)) bus ();
    logic [JCB-1:0] job_count;
    logic           err;

    seq_packet_bus_sink #(
        .PACKET_SIZE(PS), .LL_BITS(LLB), .ML_BITS(MLB), .OFF_BITS(OFB), .JOB_CNT_BITS(JCB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_job_count(job_count), .o_err(err)
    );

    typedef struct packed {
        logic [7:0]  ll;
        logic [7:0]  ml;
        logic [15:0] off;
        logic [7:0]  ovl;
        logic        eoj;
        logic        delim;
        logic        last;
    } seq_t;

    seq_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned last_emit = 0;
    int unsigned exp_jobs = 0;
    logic        exp_err = 1'b0;
    logic        hold = 1'b0;
    seq_t        snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic seq_t cur_seq();
        seq_t s;
        s.ll    = bus.o_seq_ll;
        s.ml    = bus.o_seq_ml;
        s.off   = bus.o_seq_offset;
        s.ovl   = bus.o_seq_overlap;
        s.eoj   = bus.o_seq_eoj;
        s.delim = bus.o_seq_delim;
        s.last  = bus.o_seq_last;
        return s;
    endfunction

    // Output monitor: compares every handshaken sequence and checks stalls hold steady.
    initial begin
        seq_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_stable", 64'(cur_seq()), 64'(snap));
                    check("hold_valid", 64'(bus.o_seq_valid), 64'd1);
                end
                hold = 1'b0;
                if (bus.o_seq_valid) begin
                    if (!bus.o_seq_ready) begin
                        check("hold_iready", 64'(bus.i_ready), 64'd0);
                        hold = 1'b1;
                        snap = cur_seq();
                    end else if (q.size() == 0) begin
                        check("unexp_seq", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("seq", 64'(cur_seq()), 64'(e));
                        if (e.eoj) exp_jobs++;
                        last_emit = cyc;
                    end
                end
            end
        end
    end

    task automatic send_pkt(input logic [3:0] strb, input logic [3:0] eoj, input logic [3:0] delim,
                            input logic [31:0] ll, input logic [7:0] seed);
        logic [31:0] ml, ovl;
        logic [63:0] off;
        seq_t        e;
        logic        bad;
        int          n;
        for (int k = 0; k < 4; k++) begin
            ml[k*8 +: 8]   = seed + 8'(3*k + 1);
            off[k*16 +: 16] = {seed, 8'(k + 16)};
            ovl[k*8 +: 8]  = seed ^ 8'(k + 5);
        end
        bus.i_valid   = 1'b1;
        bus.i_strb    = strb;
        bus.i_eoj     = eoj;
        bus.i_delim   = delim;
        bus.i_ll      = ll;
        bus.i_ml      = ml;
        bus.i_offset  = off;
        bus.i_overlap = ovl;
        n = 0;
        @(negedge clk);
        while (!bus.i_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.i_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            bus.i_valid = 1'b0;
            return;
        end
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (eoj[k] && (!strb[k] || ((strb >> (k + 1)) != 4'd0))) bad = 1'b1;
            if (strb[k]) begin
                e.ll    = ll[k*8 +: 8];
                e.ml    = ml[k*8 +: 8];
                e.off   = off[k*16 +: 16];
                e.ovl   = ovl[k*8 +: 8];
                e.eoj   = eoj[k];
                e.delim = delim[k];
                e.last  = ((strb >> (k + 1)) == 4'd0);
                q.push_back(e);
            end
        end
        exp_err = exp_err | bad;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_strb  = '0;
        bus.i_eoj   = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int unsigned c0;
        idle();
        bus.i_delim = '0; bus.i_ll = '0; bus.i_ml = '0; bus.i_offset = '0; bus.i_overlap = '0;
        bus.o_seq_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_iready", 64'(bus.i_ready), 64'd1);
        check("rst_valid", 64'(bus.o_seq_valid), 64'd0);
        check("rst_jobs", 64'(job_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ll", 64'(bus.o_seq_ll), 64'd0);
        @(posedge clk);
        #1;

        // strobe hole: lanes 0,1,3 on consecutive cycles
        c0 = cyc;
        send_pkt(4'b1011, 4'b0000, 4'b0000, {8'd3, 8'hEE, 8'd2, 8'd1}, 8'h10);
        idle();
        drain();
        check("t2_cycles", 64'(last_emit - c0), 64'd3);

        // back-to-back packets, no bubble
        c0 = cyc;
        send_pkt(4'b0011, 4'b0010, 4'b0010, {8'h24, 8'h23, 8'h22, 8'h21}, 8'h20);
        send_pkt(4'b0011, 4'b0010, 4'b0000, {8'h34, 8'h33, 8'h32, 8'h31}, 8'h30);
        idle();
        drain();
        check("t3_cycles", 64'(last_emit - c0), 64'd4);
        check("t3_jobs", 64'(job_count), 64'(exp_jobs));
        check("t3_jobs_two", 64'(job_count), 64'd2);

        // downstream stall 1,0,0,1 with a competing packet offered
        send_pkt(4'b1111, 4'b1000, 4'b0001, {8'h44, 8'h43, 8'h42, 8'h41}, 8'h40);
        bus.o_seq_ready = 1'b1;
        @(posedge clk); #1 bus.o_seq_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.o_seq_ready = 1'b1;
        send_pkt(4'b0100, 4'b0100, 4'b0000, {8'h54, 8'h53, 8'h52, 8'h51}, 8'h50);
        idle();
        drain();
        check("t4_jobs", 64'(job_count), 64'(exp_jobs));
        check("t4_err", 64'(err), 64'(exp_err));

        // empty packet dropped, then malformed eoj placement
        send_pkt(4'b0000, 4'b0000, 4'b1111, {8'h64, 8'h63, 8'h62, 8'h61}, 8'h60);
        idle();
        drain();
        check("t5_drop_valid", 64'(bus.o_seq_valid), 64'd0);
        check("t5_drop_err", 64'(err), 64'(exp_err));
        send_pkt(4'b0011, 4'b0001, 4'b0000, {8'h74, 8'h73, 8'h72, 8'h71}, 8'h70);
        idle();
        check("t5_err", 64'(err), 64'(exp_err));
        drain();
        check("t5_jobs", 64'(job_count), 64'(exp_jobs));

        // asynchronous reset mid-packet
        send_pkt(4'b1111, 4'b1000, 4'b0000, {8'h84, 8'h83, 8'h82, 8'h81}, 8'h80);
        idle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_valid", 64'(bus.o_seq_valid), 64'd0);
        check("t6_jobs", 64'(job_count), 64'd0);
        check("t6_err", 64'(err), 64'd0);
        q.delete();
        exp_jobs = 0;
        exp_err  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(4'b0101, 4'b0100, 4'b0100, {8'h94, 8'h93, 8'h92, 8'h91}, 8'h90);
        idle();
        drain();
        check("t6_post_jobs", 64'(job_count), 64'd1);
        check("t6_post_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end
endmodule
